// File: rtl/buzzer_arbiter.sv
// Fixed-priority arbiter sharing one piezo buzzer between NREQ requesters.
// Each grant plays a square tone for a set number of ms, then a silent guard gap.
module buzzer_arbiter #(
    parameter int NREQ   = 3,
    parameter int CLK_HZ = 50_000_000,
    parameter int HP_W   = 22,
    parameter int DUR_W  = 12,
    parameter int GAP_MS = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*HP_W-1:0]    half_period_i,
    input  logic [NREQ*DUR_W-1:0]   dur_ms_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [NREQ-1:0]         done_o,
    output logic                    busy_o,
    output logic                    buzzer_o
);
    localparam int TICKS = CLK_HZ / 1000;
    localparam int PRE_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int GAP_W = $clog2(GAP_MS + 1);
    localparam int MS_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICKS - 1);
    localparam logic [MS_W-1:0]  GAP_LAST  = MS_W'(GAP_MS - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [HP_W-1:0]   hp_reg;
    logic [HP_W-1:0]   hp_cnt_reg;
    logic [DUR_W-1:0]  dur_reg;
    logic [PRE_W-1:0]  pre_reg;
    logic [MS_W-1:0]   ms_reg;

    logic [HP_W-1:0]   hp_slice  [NREQ];
    logic [DUR_W-1:0]  dur_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign hp_slice[gi]  = half_period_i[gi*HP_W +: HP_W];
            assign dur_slice[gi] = dur_ms_i[gi*DUR_W +: DUR_W];
        end
    endgenerate

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

    logic [HP_W-1:0]  pick_hp;
    logic [DUR_W-1:0] pick_dur;
    logic [NREQ-1:0]  pick_onehot;
    logic             ms_tick;
    logic             play_last;
    logic             gap_last;
    assign pick_hp     = hp_slice[pick_idx];
    assign pick_dur    = dur_slice[pick_idx];
    assign pick_onehot = NREQ'(1) << pick_idx;
    assign ms_tick     = (pre_reg == TICK_LAST);
    assign play_last   = ms_tick && (ms_reg == MS_W'(dur_reg) - MS_W'(1));
    assign gap_last    = ms_tick && (ms_reg == GAP_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            hp_reg     <= '0;
            hp_cnt_reg <= '0;
            dur_reg    <= '0;
            pre_reg    <= '0;
            ms_reg     <= '0;
            grant_o    <= '0;
            done_o     <= '0;
            busy_o     <= 1'b0;
            buzzer_o   <= 1'b0;
        end else begin
            done_o <= '0;
            case (state_reg)
                IDLE: begin
                    pre_reg    <= '0;
                    ms_reg     <= '0;
                    hp_cnt_reg <= '0;
                    buzzer_o   <= 1'b0;
                    if (pick_valid) begin
                        idx_reg <= pick_idx;
                        hp_reg  <= (pick_hp == '0) ? HP_W'(1) : pick_hp;
                        dur_reg <= pick_dur;
                        busy_o  <= 1'b1;
                        if (pick_dur != '0) begin
                            state_reg <= PLAY;
                            grant_o   <= pick_onehot;
                        end else begin
                            state_reg <= GAP;
                            done_o    <= pick_onehot;
                        end
                    end
                end
                PLAY: begin
                    if (!req_i[idx_reg] || play_last) begin
                        // Abort takes precedence: a dropped request never gets done.
                        state_reg <= GAP;
                        done_o    <= req_i[idx_reg] ? grant_o : '0;
                        grant_o   <= '0;
                        buzzer_o  <= 1'b0;
                        pre_reg   <= '0;
                        ms_reg    <= '0;
                    end else begin
                        if (ms_tick) begin
                            pre_reg <= '0;
                            ms_reg  <= ms_reg + MS_W'(1);
                        end else begin
                            pre_reg <= pre_reg + PRE_W'(1);
                        end
                        if (hp_cnt_reg == hp_reg - HP_W'(1)) begin
                            hp_cnt_reg <= '0;
                            buzzer_o   <= ~buzzer_o;
                        end else begin
                            hp_cnt_reg <= hp_cnt_reg + HP_W'(1);
                        end
                    end
                end
                GAP: begin
                    buzzer_o <= 1'b0;
                    if (gap_last) begin
                        state_reg <= IDLE;
                        busy_o    <= 1'b0;
                        pre_reg   <= '0;
                        ms_reg    <= '0;
                    end else if (ms_tick) begin
                        pre_reg <= '0;
                        ms_reg  <= ms_reg + MS_W'(1);
                    end else begin
                        pre_reg <= pre_reg + PRE_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
